dmem_responder: RTL

Data-memory responder for the 16-bit pipelined processor: the target side of the MEM-stage load/store access. It accepts one read or write request over a valid/ready handshake, models a configurable access latency, and returns read data (or a write acknowledge) over a second valid/ready channel. It replaces the zero-wait-state data memory when the pipeline must tolerate stalls; `busy` feeds the hazard/stall logic.

---
 rtl/dmem_resp_pkg.sv | 13 +
 rtl/dmem_array.sv | 43 ++++
 rtl/dmem_responder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/dmem_resp_pkg.sv
// rtl/dmem_resp_pkg.sv - shared types and constants for the data-memory responder
package dmem_resp_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port data storage with synchronous write and strobed registered read
module dmem_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              access,
  input  logic              we,
  input  logic              zero_rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Storage is deliberately left out of reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (access && we) begin
      mem[addr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (access) begin
      rdata_d = zero_rd ? '0 : mem[addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage data responder with fixed access latency; DMEM_RESP_RANGE_CHECK_EN enables out-of-range errors
module dmem_responder
  import dmem_resp_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [15:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              oor_q, oor_d;
  logic              err_q, err_d;

  logic              req_oor;
  logic              acc;
  logic              acc_write;
  logic              acc_oor;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;

`ifdef DMEM_RESP_RANGE_CHECK_EN
  assign req_oor = |req_addr[15:ADDR_W];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[15:ADDR_W];
  assign req_oor        = 1'b0;
`endif

  // Gating with rst_n keeps a zero-latency store from landing while reset is held.
  assign req_ready = rst_n && (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    oor_d     = oor_q;
    err_d     = err_q;
    acc       = 1'b0;
    acc_write = write_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_oor   = oor_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          write_d = req_write;
          addr_d  = req_addr[ADDR_W-1:0];
          wdata_d = req_wdata;
          oor_d   = req_oor;
          if (LATENCY == 0) begin
            acc       = 1'b1;
            acc_write = req_write;
            acc_addr  = req_addr[ADDR_W-1:0];
            acc_wdata = req_wdata;
            acc_oor   = req_oor;
            state_d   = RESP;
          end else begin
            cnt_d   = LAT_M1;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          acc     = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (acc) begin
      err_d = acc_oor;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      oor_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      oor_q   <= oor_d;
      err_q   <= err_d;
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .access  (acc),
    .we      (acc_write && !acc_oor),
    .zero_rd (acc_write || acc_oor),
    .addr    (acc_addr),
    .wdata   (acc_wdata),
    .rdata   (resp_rdata)
  );

  assign resp_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign resp_err   = err_q;

endmodule
